// File: rtl/pipelined_adder.sv
// Carry-pipelined adder: WIDTH-bit a+b+cin split into STAGES chunks, one chunk per cycle, valid/ready.
// Define PIPELINED_ADDER_SAT_EN for unsigned saturation of sum when the final carry is set.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int unsigned CW = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be >= 2 and an exact multiple of STAGES");
  end

  // Whole pipeline advances together; any stall freezes every stage, bubbles included.
  logic adv_c;
  logic ovf_d;
  logic ovf_q;

  assign adv_c    = out_ready | ~out_valid;
  assign in_ready = adv_c;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned SW = (k + 1) * CW;

    logic [CW-1:0] a_c;
    logic [CW-1:0] b_c;
    logic          cin_c;
    logic          vld_d;
    logic          vld_q;
    logic          cy_q;
    logic [CW:0]   add_c;
    logic [SW-1:0] sum_cat_c;
    logic [SW-1:0] sum_d;
    logic [SW-1:0] sum_q;

    if (k == 0) begin : g_head
      assign a_c       = a[CW-1:0];
      assign b_c       = b[CW-1:0];
      assign cin_c     = cin;
      assign vld_d     = in_valid;
      assign sum_cat_c = add_c[CW-1:0];
    end else begin : g_tail
      assign a_c       = g_stg[k-1].g_ops.a_q[CW-1:0];
      assign b_c       = g_stg[k-1].g_ops.b_q[CW-1:0];
      assign cin_c     = g_stg[k-1].cy_q;
      assign vld_d     = g_stg[k-1].vld_q;
      assign sum_cat_c = {add_c[CW-1:0], g_stg[k-1].sum_q};
    end

    assign add_c = {1'b0, a_c} + {1'b0, b_c} + {{CW{1'b0}}, cin_c};

    // Upper operand chunks ride along, shifted so the next stage always reads the low chunk.
    if (k < STAGES - 1) begin : g_ops
      localparam int unsigned OW = WIDTH - SW;
      logic [OW-1:0] a_d;
      logic [OW-1:0] b_d;
      logic [OW-1:0] a_q;
      logic [OW-1:0] b_q;

      if (k == 0) begin : g_src_port
        assign a_d = a[WIDTH-1:CW];
        assign b_d = b[WIDTH-1:CW];
      end else begin : g_src_prev
        assign a_d = g_stg[k-1].g_ops.a_q[OW+CW-1:CW];
        assign b_d = g_stg[k-1].g_ops.b_q[OW+CW-1:CW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv_c && vld_d) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      // Carry into the MSB is recovered as a^b^sum at that bit.
      assign ovf_d = a_c[CW-1] ^ b_c[CW-1] ^ add_c[CW-1] ^ add_c[CW];
`ifdef PIPELINED_ADDER_SAT_EN
      assign sum_d = add_c[CW] ? '1 : sum_cat_c;
`else
      assign sum_d = sum_cat_c;
`endif
    end else begin : g_mid
      assign sum_d = sum_cat_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (adv_c) begin
        vld_q <= vld_d;
        if (vld_d) begin
          cy_q  <= add_c[CW];
          sum_q <= sum_d;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv_c && g_stg[STAGES-1].vld_d) begin
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = g_stg[STAGES-1].vld_q;
  assign sum       = g_stg[STAGES-1].sum_q;
  assign cout      = g_stg[STAGES-1].cy_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: 16/4 main instance plus 4/1 and 8/8 corner instances.
// Follows PIPELINED_ADDER_SAT_EN in its reference model when that macro is defined.
module tb_pipelined_adder;
  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Main instance
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;
  // WIDTH=4, STAGES=1
  logic         iv4, ir4, ci4, ov4, or4, co4, of4;
  logic [3:0]   a4, b4, s4;
  // WIDTH=8, STAGES=8
  logic         iv8, ir8, ci8, ov8, or8, co8, of8;
  logic [7:0]   a8, b8, s8;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

  pipelined_adder #(.WIDTH(4), .STAGES(1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(ci4),
    .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(of4));

  pipelined_adder #(.WIDTH(8), .STAGES(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(ci8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8));

  // Reference: exact integer arithmetic, then reduce to a w-bit result.
  function automatic void ref_add(input int w, input longint unsigned x, input longint unsigned y,
                                  input bit ci, output longint unsigned s, output bit co,
                                  output bit ov);
    longint unsigned one  = 1;
    longint unsigned full = x + y + (ci ? one : 0);
    longint          lim  = longint'(one << (w - 1));
    longint          sx   = longint'(x);
    longint          sy   = longint'(y);
    longint          ss;
    if (x >= (one << (w - 1))) sx = sx - 2 * lim;
    if (y >= (one << (w - 1))) sy = sy - 2 * lim;
    ss = sx + sy + (ci ? 1 : 0);
    s  = full & ((one << w) - 1);
    co = ((full >> w) & one) != 0;
    ov = (ss > lim - 1) || (ss < -lim);
`ifdef PIPELINED_ADDER_SAT_EN
    if (co) s = (one << w) - 1;
`endif
  endfunction

  // Issue one op on the idle main pipeline; report cycles until out_valid and the result seen.
  task automatic single_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                           output int lat, output logic [W-1:0] os, output logic oc,
                           output logic oo);
    lat = -1; os = '0; oc = 1'b0; oo = 1'b0;
    @(negedge clk);
    a = ia; b = ib; cin = ic; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        lat = i; os = sum; oc = cout; oo = ovf;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; ci4 = 1'b0;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; ci8 = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0)
      $display("FAIL reset_outputs: got v=%b sum=%h cout=%b ovf=%b, need all zero",
               out_valid, sum, cout, ovf);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b need 1", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b need 0", out_valid);
    else n_pass++;
  endtask

  // Table of directed single ops: basic add, chunk-crossing carries, signed overflow.
  task automatic test_directed();
    logic [W-1:0] ta[5] = '{16'h0001, 16'hFFFF, 16'h00FF, 16'h7FFF, 16'h8000};
    logic [W-1:0] tb[5] = '{16'h0002, 16'h0001, 16'h0001, 16'h0001, 16'h8000};
    int lat; logic [W-1:0] os; logic oc, oo;
    longint unsigned ms; bit mc, mo;
    for (int i = 0; i < 5; i++) begin
      single_op(ta[i], tb[i], 1'b0, lat, os, oc, oo);
      ref_add(W, 64'(ta[i]), 64'(tb[i]), 1'b0, ms, mc, mo);
      n_checks++;
      if (lat != int'(S)) $display("FAIL directed_latency[%0d]: got %0d need %0d", i, lat, S);
      else n_pass++;
      n_checks++;
      if (os !== W'(ms) || oc !== mc || oo !== mo)
        $display("FAIL directed_result[%0d]: got sum=%h cout=%b ovf=%b need sum=%h cout=%b ovf=%b",
                 i, os, oc, oo, W'(ms), mc, mo);
      else n_pass++;
    end
  endtask

  // Eight ops issued on consecutive cycles with a three-cycle downstream stall once full.
  task automatic test_back_to_back();
    logic [W-1:0] qa[$], qb[$], es[$];
    logic         qc[$], ec[$], eo[$];
    longint unsigned ms; bit mc, mo;
    logic [W-1:0] ps; logic pc, po, stalled;
    bit exp_rdy;
    int got;
    got = 0; stalled = 1'b0; ps = '0; pc = 1'b0; po = 1'b0;
    for (int i = 0; i < 8; i++) begin
      qa.push_back(W'($urandom)); qb.push_back(W'($urandom)); qc.push_back(1'($urandom));
    end
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      in_valid = (qa.size() != 0);
      if (qa.size() != 0) begin a = qa[0]; b = qb[0]; cin = qc[0]; end
      exp_rdy   = !(c >= 5 && c <= 7);
      out_ready = exp_rdy;
      #1;
      n_checks++;
      if (in_ready !== exp_rdy) $display("FAIL b2b_in_ready c=%0d: got %b need %b", c, in_ready, exp_rdy);
      else n_pass++;
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || sum !== ps || cout !== pc || ovf !== po)
          $display("FAIL b2b_hold c=%0d: got v=%b sum=%h cout=%b ovf=%b need v=1 sum=%h cout=%b ovf=%b",
                   c, out_valid, sum, cout, ovf, ps, pc, po);
        else n_pass++;
      end
      if (in_valid && in_ready === 1'b1) begin
        ref_add(W, 64'(qa[0]), 64'(qb[0]), qc[0], ms, mc, mo);
        es.push_back(W'(ms)); ec.push_back(mc); eo.push_back(mo);
        void'(qa.pop_front()); void'(qb.pop_front()); void'(qc.pop_front());
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (es.size() == 0) $display("FAIL b2b_extra: got sum=%h need no output", sum);
        else begin
          if (sum !== es[0] || cout !== ec[0] || ovf !== eo[0])
            $display("FAIL b2b_result[%0d]: got sum=%h cout=%b ovf=%b need sum=%h cout=%b ovf=%b",
                     got, sum, cout, ovf, es[0], ec[0], eo[0]);
          else n_pass++;
          void'(es.pop_front()); void'(ec.pop_front()); void'(eo.pop_front());
        end
        got++;
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      ps = sum; pc = cout; po = ovf;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (got != 8) $display("FAIL b2b_count: got %0d results need 8", got);
    else n_pass++;
  endtask

  // Reset with three ops in flight (first one stalled at the output) discards all of them.
  task automatic test_reset_flush();
    int lat; logic [W-1:0] os; logic oc, oo;
    longint unsigned ms; bit mc, mo;
    bit seen;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL flush_pre_valid: got %b need 1", out_valid);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0)
      $display("FAIL flush_async_clear: got v=%b sum=%h cout=%b need 0/0000/0", out_valid, sum, cout);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL flush_no_ghost: got out_valid=1 after reset need 0");
    else n_pass++;
    single_op(16'h1234, 16'h4321, 1'b1, lat, os, oc, oo);
    ref_add(W, 64'(16'h1234), 64'(16'h4321), 1'b1, ms, mc, mo);
    n_checks++;
    if (lat != int'(S) || os !== W'(ms))
      $display("FAIL flush_next_op: got lat=%0d sum=%h need lat=%0d sum=%h", lat, os, S, W'(ms));
    else n_pass++;
  endtask

  // WIDTH=4 STAGES=1: a single registered adder, result one cycle after accept.
  task automatic test_single_stage();
    logic [3:0] va, vb; logic vc;
    longint unsigned ms; bit mc, mo;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin va = 4'hA; vb = 4'h5; vc = 1'b1; end
      else begin va = 4'($urandom); vb = 4'($urandom); vc = 1'($urandom); end
      @(negedge clk);
      iv4 = 1'b1; a4 = va; b4 = vb; ci4 = vc;
      @(negedge clk);
      iv4 = 1'b0;
      ref_add(4, 64'(va), 64'(vb), vc, ms, mc, mo);
      n_checks++;
      if (ov4 !== 1'b1 || s4 !== 4'(ms) || co4 !== mc || of4 !== mo)
        $display("FAIL w4_result[%0d]: got v=%b sum=%h cout=%b ovf=%b need v=1 sum=%h cout=%b ovf=%b",
                 i, ov4, s4, co4, of4, 4'(ms), mc, mo);
      else n_pass++;
    end
  endtask

  // WIDTH=8 STAGES=8: random stream with random input gaps and random downstream back-pressure.
  task automatic test_bit_serial_sweep();
    logic [7:0] es[$]; logic ec[$], eo[$];
    longint unsigned ms; bit mc, mo;
    int sent, got;
    sent = 0; got = 0;
    for (int c = 0; c < 400 && got < 30; c++) begin
      @(negedge clk);
      if (!(iv8 && ir8 !== 1'b1)) begin
        iv8 = (sent < 30) && ($urandom_range(0, 3) != 0);
        a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      end
      or8 = ($urandom_range(0, 3) != 0);
      #1;
      if (iv8 && ir8 === 1'b1) begin
        ref_add(8, 64'(a8), 64'(b8), ci8, ms, mc, mo);
        es.push_back(8'(ms)); ec.push_back(mc); eo.push_back(mo);
        sent++;
      end
      if (ov8 === 1'b1 && or8) begin
        n_checks++;
        if (es.size() == 0) $display("FAIL w8_extra: got sum=%h need no output", s8);
        else begin
          if (s8 !== es[0] || co8 !== ec[0] || of8 !== eo[0])
            $display("FAIL w8_result[%0d]: got sum=%h cout=%b ovf=%b need sum=%h cout=%b ovf=%b",
                     got, s8, co8, of8, es[0], ec[0], eo[0]);
          else n_pass++;
          void'(es.pop_front()); void'(ec.pop_front()); void'(eo.pop_front());
        end
        got++;
      end
    end
    iv8 = 1'b0;
    n_checks++;
    if (got != 30) $display("FAIL w8_count: got %0d results need 30", got);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_flush();
    test_single_stage();
    test_bit_serial_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
